regfile_mp: RTL and testbench

Parametrised multi-port register file, successor to the single-write/dual-read file in the pipeline datapath.
- Two write ports (ALU writeback and load writeback), NRD read ports with write-through forwarding, optional hardwired-zero R0.
- A per-register pending scoreboard for long-latency producers.
- A multi-cycle soft-clear sequencer that restores the init table without a hard reset.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_fwd_mux.sv | 47 ++++
 rtl/regfile_mp.sv | 155 +++++++++++++++
 tb/tb_regfile_mp.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, FSM encoding and the power-on init table for the
// multi-port register file.
package regfile_pkg;

  localparam int unsigned DSIZE_DEF   = 16;
  localparam int unsigned NREG_DEF    = 16;
  localparam int unsigned ASIZE_DEF   = 4;
  localparam int unsigned NRD_DEF     = 2;
  localparam int unsigned ZERO_R0_DEF = 0;

  localparam int unsigned INIT_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Reset / soft-clear value of each register; callers size it to DSIZE.
  function automatic logic [INIT_W-1:0] init_value(input int unsigned idx);
    case (idx)
      2:       init_value = 16'h0F8C;
      4:       init_value = 16'h4890;
      6:       init_value = 16'h4F80;
      7:       init_value = 16'h0003;
      8:       init_value = 16'h8FF9;
      default: init_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port: hardwired-zero / out-of-range / write-through / array
// select, plus the port's scoreboard-derived valid flag.
module regfile_fwd_mux #(
  parameter int unsigned DSIZE   = 16,
  parameter int unsigned ASIZE   = 4,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic [ASIZE-1:0] raddr,
  input  logic             in_range,
  input  logic             idle,
  input  logic             wen0,
  input  logic [ASIZE-1:0] waddr0,
  input  logic [DSIZE-1:0] wdata0,
  input  logic             wen1,
  input  logic [ASIZE-1:0] waddr1,
  input  logic [DSIZE-1:0] wdata1,
  input  logic [DSIZE-1:0] arr_data,
  input  logic             pend,
  output logic [DSIZE-1:0] rdata_c,
  output logic             rvalid_c
);

  localparam bit ZR = (ZERO_R0 != 0);

  logic is_zero_c;
  logic hit0_c;
  logic hit1_c;

  assign is_zero_c = ZR && (raddr == '0);
  assign hit1_c    = idle & wen1 & (waddr1 == raddr);
  assign hit0_c    = idle & wen0 & (waddr0 == raddr);

  // Port 1 forwards ahead of port 0, matching the write priority.
  always_comb begin
    rdata_c  = arr_data;
    rvalid_c = ~pend | hit0_c | hit1_c;
    if (is_zero_c || !in_range) begin
      rdata_c  = '0;
      rvalid_c = 1'b1;
    end else if (hit1_c) begin
      rdata_c = wdata1;
    end else if (hit0_c) begin
      rdata_c = wdata0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Dual-write, NRD-read register file with write-through forwarding, a
// pending-producer scoreboard and a soft-clear sweep back to the init table.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DSIZE   = DSIZE_DEF,
  parameter int unsigned NREG    = NREG_DEF,
  parameter int unsigned ASIZE   = ASIZE_DEF,
  parameter int unsigned NRD     = NRD_DEF,
  parameter int unsigned ZERO_R0 = ZERO_R0_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen0,
  input  logic [ASIZE-1:0]     waddr0,
  input  logic [DSIZE-1:0]     wdata0,
  input  logic                 wen1,
  input  logic [ASIZE-1:0]     waddr1,
  input  logic [DSIZE-1:0]     wdata1,
  input  logic [NRD*ASIZE-1:0] raddr,
  output logic [NRD*DSIZE-1:0] rdata,
  output logic [NRD-1:0]       rvalid,
  input  logic                 pend_set,
  input  logic [ASIZE-1:0]     pend_addr,
  input  logic                 clr_req,
  output logic                 ready,
  output logic                 pend_any
);

  localparam logic [ASIZE:0]   NREG_W = (ASIZE+1)'(NREG);
  localparam logic [ASIZE-1:0] LAST   = ASIZE'(NREG - 1);
  localparam bit               ZR     = (ZERO_R0 != 0);

  state_t                 state_q, state_d;
  logic [ASIZE-1:0]       idx_q, idx_d;
  logic [NREG*DSIZE-1:0]  mem_flat;
  logic [NREG-1:0]        pending;
  logic                   idle_c;
  logic                   w0_ok_c, w1_ok_c, ps_ok_c;

  assign idle_c  = (state_q == ST_IDLE);
  assign w0_ok_c = idle_c & wen0 & ({1'b0, waddr0} < NREG_W) & ~(ZR & (waddr0 == '0));
  assign w1_ok_c = idle_c & wen1 & ({1'b0, waddr1} < NREG_W) & ~(ZR & (waddr1 == '0));
  assign ps_ok_c = idle_c & pend_set & ({1'b0, pend_addr} < NREG_W) & ~(ZR & (pend_addr == '0));

  assign ready    = idle_c;
  assign pend_any = |pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Soft-clear sequencer: one register restored per cycle, idx 0..NREG-1.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        idx_d = idx_q + ASIZE'(1);
        if (idx_q == LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-register storage and pending bit; pend_set beats a same-cycle write clear.
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    localparam logic [ASIZE-1:0] GA = ASIZE'(g);
    localparam logic [DSIZE-1:0] GI = DSIZE'(init_value(g));

    logic [DSIZE-1:0] data_q;
    logic             pend_q;
    logic             hit1_c, hit0_c;

    assign hit1_c = w1_ok_c & (waddr1 == GA);
    assign hit0_c = w0_ok_c & (waddr0 == GA);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q <= GI;
        pend_q <= 1'b0;
      end else if (!idle_c) begin
        if (idx_q == GA) begin
          data_q <= GI;
          pend_q <= 1'b0;
        end
      end else begin
        if (hit1_c)      data_q <= wdata1;
        else if (hit0_c) data_q <= wdata0;
        if (ps_ok_c && (pend_addr == GA)) pend_q <= 1'b1;
        else if (hit1_c || hit0_c)        pend_q <= 1'b0;
      end
    end

    assign mem_flat[g*DSIZE +: DSIZE] = data_q;
    assign pending[g]                 = pend_q;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ASIZE-1:0] ra;
    logic [DSIZE-1:0] arr_c;
    logic             pend_c;
    logic             in_range_c;

    assign ra         = raddr[k*ASIZE +: ASIZE];
    assign in_range_c = ({1'b0, ra} < NREG_W);

    always_comb begin
      arr_c  = '0;
      pend_c = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        if (ra == ASIZE'(i)) begin
          arr_c  = mem_flat[i*DSIZE +: DSIZE];
          pend_c = pending[i];
        end
      end
    end

    regfile_fwd_mux #(
      .DSIZE   (DSIZE),
      .ASIZE   (ASIZE),
      .ZERO_R0 (ZERO_R0)
    ) u_mux (
      .raddr    (ra),
      .in_range (in_range_c),
      .idle     (idle_c),
      .wen0     (wen0),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .wen1     (wen1),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
      .arr_data (arr_c),
      .pend     (pend_c),
      .rdata_c  (rdata[k*DSIZE +: DSIZE]),
      .rvalid_c (rvalid[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus a randomized
// run against a behavioural model; a second instance covers ZERO_R0 and NREG < 2**ASIZE.
module tb_regfile_mp;

  localparam int unsigned DW  = 16;
  localparam int unsigned NR  = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned RD  = 2;
  localparam int unsigned ZNR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (defaults)
  logic           rst;
  logic           wen0, wen1, pend_set, clr_req;
  logic [AW-1:0]  waddr0, waddr1, pend_addr;
  logic [DW-1:0]  wdata0, wdata1;
  logic [RD*AW-1:0] raddr;
  logic [RD*DW-1:0] rdata;
  logic [RD-1:0]  rvalid;
  logic           ready, pend_any;
  logic [DW-1:0]  rd0, rd1;
  assign rd0 = rdata[DW-1:0];
  assign rd1 = rdata[2*DW-1:DW];

  // second instance: ZERO_R0=1, NREG=8
  logic           z_rst;
  logic           z_wen0, z_wen1, z_pend_set, z_clr_req;
  logic [AW-1:0]  z_waddr0, z_waddr1, z_pend_addr;
  logic [DW-1:0]  z_wdata0, z_wdata1;
  logic [RD*AW-1:0] z_raddr;
  logic [RD*DW-1:0] z_rdata;
  logic [RD-1:0]  z_rvalid;
  logic           z_ready, z_pend_any;
  logic [DW-1:0]  z_rd0, z_rd1;
  assign z_rd0 = z_rdata[DW-1:0];
  assign z_rd1 = z_rdata[2*DW-1:DW];

  int total = 0;
  int bad   = 0;

  regfile_mp #(.DSIZE(DW), .NREG(NR), .ASIZE(AW), .NRD(RD), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .pend_set(pend_set), .pend_addr(pend_addr), .clr_req(clr_req),
    .ready(ready), .pend_any(pend_any)
  );

  regfile_mp #(.DSIZE(DW), .NREG(ZNR), .ASIZE(AW), .NRD(RD), .ZERO_R0(1)) dutz (
    .clk(clk), .rst(z_rst),
    .wen0(z_wen0), .waddr0(z_waddr0), .wdata0(z_wdata0),
    .wen1(z_wen1), .waddr1(z_waddr1), .wdata1(z_wdata1),
    .raddr(z_raddr), .rdata(z_rdata), .rvalid(z_rvalid),
    .pend_set(z_pend_set), .pend_addr(z_pend_addr), .clr_req(z_clr_req),
    .ready(z_ready), .pend_any(z_pend_any)
  );

  // Behavioural model of the main instance.
  logic [DW-1:0] m_reg [NR];
  bit            m_pend [NR];
  bit            m_sweep;
  int            m_idx;

  function automatic logic [DW-1:0] ref_init(input int i);
    case (i)
      2: return 16'h0F8C;
      4: return 16'h4890;
      6: return 16'h4F80;
      7: return 16'h0003;
      8: return 16'h8FF9;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = ref_init(i);
      m_pend[i] = 1'b0;
    end
    m_sweep = 1'b0;
    m_idx   = 0;
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (!m_sweep && wen1 && waddr1 == a) return wdata1;
    if (!m_sweep && wen0 && waddr0 == a) return wdata0;
    return m_reg[a];
  endfunction

  function automatic logic ref_valid(input logic [AW-1:0] a);
    return !m_pend[a] || (!m_sweep && ((wen1 && waddr1 == a) || (wen0 && waddr0 == a)));
  endfunction

  function automatic logic ref_pend_any();
    for (int i = 0; i < NR; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model with the inputs present at this edge, then cross the edge.
  task automatic tick();
    if (m_sweep) begin
      m_reg[m_idx]  = ref_init(m_idx);
      m_pend[m_idx] = 1'b0;
      m_idx++;
      if (m_idx == NR) m_sweep = 1'b0;
    end else begin
      if (wen0) m_reg[waddr0] = wdata0;
      if (wen1) m_reg[waddr1] = wdata1;
      if (wen0) m_pend[waddr0] = 1'b0;
      if (wen1) m_pend[waddr1] = 1'b0;
      if (pend_set) m_pend[pend_addr] = 1'b1;
      if (clr_req) begin
        m_sweep = 1'b1;
        m_idx   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wen0 = 0; wen1 = 0; pend_set = 0; clr_req = 0;
    waddr0 = '0; waddr1 = '0; pend_addr = '0; wdata0 = '0; wdata1 = '0;
    z_wen0 = 0; z_wen1 = 0; z_pend_set = 0; z_clr_req = 0;
    z_waddr0 = '0; z_waddr1 = '0; z_pend_addr = '0; z_wdata0 = '0; z_wdata1 = '0;
  endtask

  task automatic test_reset();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", ready); end
    total++; if (pend_any !== 1'b0) begin bad++; $display("FAIL reset_pend_any got %b want 0", pend_any); end
    for (int i = 0; i < NR; i++) begin
      raddr = {AW'(NR - 1 - i), AW'(i)};
      #1;
      total++; if (rd0 !== ref_init(i)) begin bad++; $display("FAIL reset_r%0d got %h want %h", i, rd0, ref_init(i)); end
      total++; if (rd1 !== ref_init(NR - 1 - i)) begin bad++; $display("FAIL reset_r%0d got %h want %h", NR - 1 - i, rd1, ref_init(NR - 1 - i)); end
      total++; if (rvalid !== 2'b11) begin bad++; $display("FAIL reset_rvalid got %b want 11", rvalid); end
      tick();
    end
  endtask

  task automatic test_dual_write();
    wen0 = 1; waddr0 = 4'd3; wdata0 = 16'h1111;
    wen1 = 1; waddr1 = 4'd3; wdata1 = 16'h2222;
    raddr = {4'd5, 4'd3};
    #1;
    total++; if (rd0 !== 16'h2222) begin bad++; $display("FAIL dual_fwd got %h want 2222", rd0); end
    tick();
    wen0 = 0; wen1 = 0;
    #1;
    total++; if (rd0 !== 16'h2222) begin bad++; $display("FAIL dual_array got %h want 2222", rd0); end
    wen0 = 1; waddr0 = 4'd5; wdata0 = 16'hABCD;
    #1;
    total++; if (rd1 !== 16'hABCD) begin bad++; $display("FAIL w0_fwd got %h want abcd", rd1); end
    tick();
    wen0 = 0;
    #1;
    total++; if (rd1 !== 16'hABCD) begin bad++; $display("FAIL w0_array got %h want abcd", rd1); end
  endtask

  task automatic test_pending();
    pend_set = 1; pend_addr = 4'd9; raddr = {4'd0, 4'd9};
    tick();
    pend_set = 0;
    #1;
    total++; if (rvalid[0] !== 1'b0) begin bad++; $display("FAIL pend_rvalid got %b want 0", rvalid[0]); end
    total++; if (pend_any !== 1'b1) begin bad++; $display("FAIL pend_any_set got %b want 1", pend_any); end
    wen1 = 1; waddr1 = 4'd9; wdata1 = 16'h0042;
    #1;
    total++; if (rvalid[0] !== 1'b1) begin bad++; $display("FAIL pend_wt_rvalid got %b want 1", rvalid[0]); end
    total++; if (rd0 !== 16'h0042) begin bad++; $display("FAIL pend_wt_rdata got %h want 0042", rd0); end
    tick();
    wen1 = 0;
    #1;
    total++; if (rvalid[0] !== 1'b1) begin bad++; $display("FAIL pend_clr_rvalid got %b want 1", rvalid[0]); end
    total++; if (pend_any !== 1'b0) begin bad++; $display("FAIL pend_any_clr got %b want 0", pend_any); end
  endtask

  task automatic test_set_clear_same();
    pend_set = 1; pend_addr = 4'd9;
    wen0 = 1; waddr0 = 4'd9; wdata0 = 16'h3C3C; raddr = {4'd0, 4'd9};
    tick();
    pend_set = 0; wen0 = 0;
    #1;
    total++; if (rd0 !== 16'h3C3C) begin bad++; $display("FAIL setclr_data got %h want 3c3c", rd0); end
    total++; if (rvalid[0] !== 1'b0) begin bad++; $display("FAIL setclr_rvalid got %b want 0", rvalid[0]); end
    total++; if (pend_any !== 1'b1) begin bad++; $display("FAIL setclr_pend_any got %b want 1", pend_any); end
    wen0 = 1; waddr0 = 4'd9; wdata0 = 16'h0009;
    tick();
    wen0 = 0;
  endtask

  task automatic test_soft_clear();
    int n;
    wen0 = 1; waddr0 = 4'd2; wdata0 = 16'hFFFF;
    tick();
    wen0 = 0; pend_set = 1; pend_addr = 4'd4;
    tick();
    pend_set = 0; clr_req = 1;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL clr_ready_before got %b want 1", ready); end
    tick();
    clr_req = 0;
    n = 0;
    while (ready === 1'b0 && n < 40) begin
      n++;
      if (n == 5) begin
        wen0 = 1; waddr0 = 4'd10; wdata0 = 16'h5555; raddr = {4'd2, 4'd10};
        #1;
        total++; if (rd0 !== 16'h0000) begin bad++; $display("FAIL sweep_no_fwd got %h want 0000", rd0); end
      end
      tick();
      wen0 = 0;
    end
    total++; if (n != NR) begin bad++; $display("FAIL sweep_len got %0d want %0d", n, NR); end
    raddr = {4'd10, 4'd2};
    #1;
    total++; if (rd0 !== 16'h0F8C) begin bad++; $display("FAIL sweep_r2 got %h want 0f8c", rd0); end
    total++; if (rd1 !== 16'h0000) begin bad++; $display("FAIL sweep_r10 got %h want 0000", rd1); end
    total++; if (pend_any !== 1'b0) begin bad++; $display("FAIL sweep_pend_any got %b want 0", pend_any); end
  endtask

  task automatic test_clr_held();
    int n;
    clr_req = 1;
    tick();
    n = 0;
    while (ready === 1'b0 && n < 40) begin
      n++;
      tick();
    end
    total++; if (n != NR) begin bad++; $display("FAIL held_len got %0d want %0d", n, NR); end
    tick();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL held_retrigger got %b want 0", ready); end
    clr_req = 0;
    n = 0;
    while (ready === 1'b0 && n < 40) begin
      n++;
      tick();
    end
    total++; if (n != NR) begin bad++; $display("FAIL held_len2 got %0d want %0d", n, NR); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 300; c++) begin
      wen0 = 1'($urandom_range(0, 1)); waddr0 = AW'($urandom); wdata0 = DW'($urandom);
      wen1 = ($urandom_range(0, 2) == 0); waddr1 = AW'($urandom); wdata1 = DW'($urandom);
      if ($urandom_range(0, 1) == 1) waddr1 = waddr0;
      pend_set = ($urandom_range(0, 3) == 0); pend_addr = AW'($urandom);
      clr_req = ($urandom_range(0, 59) == 0);
      raddr = (RD*AW)'($urandom);
      if ($urandom_range(0, 1) == 1) raddr[AW-1:0] = waddr0;
      #1;
      for (int k = 0; k < RD; k++) begin
        a = raddr[k*AW +: AW];
        total++; if (rdata[k*DW +: DW] !== ref_read(a)) begin bad++;
          $display("FAIL rand_rdata cyc %0d port %0d addr %0d got %h want %h", c, k, a, rdata[k*DW +: DW], ref_read(a)); end
        total++; if (rvalid[k] !== ref_valid(a)) begin bad++;
          $display("FAIL rand_rvalid cyc %0d port %0d addr %0d got %b want %b", c, k, a, rvalid[k], ref_valid(a)); end
      end
      total++; if (ready !== !m_sweep) begin bad++; $display("FAIL rand_ready cyc %0d got %b want %b", c, ready, !m_sweep); end
      total++; if (pend_any !== ref_pend_any()) begin bad++; $display("FAIL rand_pend_any cyc %0d got %b want %b", c, pend_any, ref_pend_any()); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_zero_r0();
    logic [DW-1:0] exp;
    for (int i = 0; i < 10; i++) begin
      z_raddr = {AW'(i), AW'(i)};
      exp = (i < ZNR) ? ref_init(i) : 16'h0000;
      #1;
      total++; if (z_rd0 !== exp) begin bad++; $display("FAIL z_reset_r%0d got %h want %h", i, z_rd0, exp); end
      total++; if (z_rvalid[0] !== 1'b1) begin bad++; $display("FAIL z_reset_rvalid r%0d got %b want 1", i, z_rvalid[0]); end
      tick();
    end
    z_wen0 = 1; z_waddr0 = 4'd0; z_wdata0 = 16'h7777;
    z_pend_set = 1; z_pend_addr = 4'd0; z_raddr = {4'd0, 4'd0};
    #1;
    total++; if (z_rd0 !== 16'h0000) begin bad++; $display("FAIL z_r0_fwd got %h want 0000", z_rd0); end
    tick();
    z_wen0 = 0; z_pend_set = 0;
    #1;
    total++; if (z_rd0 !== 16'h0000) begin bad++; $display("FAIL z_r0_after got %h want 0000", z_rd0); end
    total++; if (z_rvalid[0] !== 1'b1) begin bad++; $display("FAIL z_r0_rvalid got %b want 1", z_rvalid[0]); end
    total++; if (z_pend_any !== 1'b0) begin bad++; $display("FAIL z_r0_pend_any got %b want 0", z_pend_any); end
    z_wen1 = 1; z_waddr1 = 4'd8; z_wdata1 = 16'h1234;
    z_pend_set = 1; z_pend_addr = 4'd9;
    tick();
    z_wen1 = 0; z_pend_set = 0; z_raddr = {4'd9, 4'd8};
    #1;
    total++; if (z_rd0 !== 16'h0000) begin bad++; $display("FAIL z_oor_r8 got %h want 0000", z_rd0); end
    total++; if (z_pend_any !== 1'b0) begin bad++; $display("FAIL z_oor_pend got %b want 0", z_pend_any); end
    z_wen0 = 1; z_waddr0 = 4'd3; z_wdata0 = 16'hBEEF;
    tick();
    z_wen0 = 0; z_clr_req = 1; z_raddr = {4'd2, 4'd3};
    tick();
    z_clr_req = 0;
    tick();
    tick();
    total++; if (z_ready !== 1'b0) begin bad++; $display("FAIL z_sweep_ready got %b want 0", z_ready); end
    total++; if (z_rd0 !== 16'hBEEF) begin bad++; $display("FAIL z_sweep_r3 got %h want beef", z_rd0); end
    z_rst = 0;
    #1;
    total++; if (z_ready !== 1'b1) begin bad++; $display("FAIL z_rst_ready got %b want 1", z_ready); end
    total++; if (z_rd0 !== 16'h0000) begin bad++; $display("FAIL z_rst_r3 got %h want 0000", z_rd0); end
    total++; if (z_rd1 !== 16'h0F8C) begin bad++; $display("FAIL z_rst_r2 got %h want 0f8c", z_rd1); end
    z_rst = 1;
    tick();
    total++; if (z_ready !== 1'b1) begin bad++; $display("FAIL z_post_rst_ready got %b want 1", z_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    raddr = '0; z_raddr = '0;
    rst = 0; z_rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1; z_rst = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_dual_write();
    test_pending();
    test_set_clear_same();
    test_soft_clear();
    test_clr_held();
    test_random();
    test_zero_r0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
